// File: rtl/write_source_arbiter.sv
// write_source_arbiter
//   Arbitrates NUM_SRC write sources onto one registered DATA_W-wide write
//   stream toward the single memory write port. A winning source is locked
//   for a whole burst (until it delivers a word with its last flag set).
//   Arbitration is fixed priority (index 0 highest, MODE=0) or round-robin
//   (MODE=1).
//
//   Handshake rule (both sides): a word moves across an interface on a rising
//   clock edge where valid and ready are both high; valid never waits on ready.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   src_valid  per-source word valid
//   src_data   packed source words, source i at [i*DATA_W +: DATA_W]
//   src_last   per-source end-of-burst flag, qualified by src_valid
//   src_ready  per-source accept, one-hot or zero
//   out_valid  output word valid
//   out_data   registered output word
//   out_src    index of the source that produced out_data
//   out_last   registered last flag of out_data
//   out_ready  downstream accept
//   busy       high while a burst is locked (exposes the FSM state)
module write_source_arbiter #(
   parameter int DATA_W  = 16,
   parameter int NUM_SRC = 4,
   parameter int MODE    = 0,
   parameter int SRC_W   = $clog2(NUM_SRC)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_SRC-1:0]        src_valid,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   input  logic [NUM_SRC-1:0]        src_last,
   output logic [NUM_SRC-1:0]        src_ready,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   output logic [SRC_W-1:0]          out_src,
   output logic                      out_last,
   input  logic                      out_ready,
   output logic                      busy
);

   typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

   state_t              state, state_next;
   logic [SRC_W-1:0]    grant, grant_next;
   logic [SRC_W-1:0]    rr_ptr, rr_next;
   logic [SRC_W-1:0]    winner, low_any, low_up;
   logic                any_valid, has_up;
   logic                sel_valid, sel_last;
   logic [DATA_W-1:0]   sel_data;
   logic                take;
   logic                accept;

   // Output register can take a word when empty or being drained this cycle.
   assign take      = !out_valid || out_ready;
   assign any_valid = |src_valid;
   assign busy      = (state == LOCK);
   assign accept    = (state == LOCK) && sel_valid && take;

   // Winner search. Scanning downward leaves the lowest matching index.
   // low_up is the lowest requester at or above rr_ptr; if none exists the
   // round-robin search wraps, which is the lowest requester overall.
   always_comb begin
      low_any = '0;
      low_up  = '0;
      has_up  = 1'b0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (src_valid[i]) begin
            low_any = SRC_W'(i);
            if (SRC_W'(i) >= rr_ptr) begin
               low_up = SRC_W'(i);
               has_up = 1'b1;
            end
         end
      end
      winner = (MODE == 1 && has_up) ? low_up : low_any;
   end

   // Mux the granted source and build the one-hot ready.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      src_ready = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant == SRC_W'(i)) begin
            sel_valid    = src_valid[i];
            sel_last     = src_last[i];
            sel_data     = src_data[i*DATA_W +: DATA_W];
            src_ready[i] = (state == LOCK) && take;
         end
      end
   end

   // Next-state logic. Other requesters never break a lock; only the granted
   // source's last beat releases it.
   always_comb begin
      state_next = state;
      grant_next = grant;
      rr_next    = rr_ptr;
      case (state)
         IDLE: begin
            if (any_valid) begin
               state_next = LOCK;
               grant_next = winner;
            end
         end
         LOCK: begin
            if (accept && sel_last) begin
               state_next = IDLE;
               if (MODE == 1) begin
                  rr_next = (grant == SRC_W'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         grant  <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_next;
         grant  <= grant_next;
         rr_ptr <= rr_next;
      end
   end

   // Output register: a new accept overwrites a word being drained in the
   // same edge, so bursts stream at one word per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         out_last  <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_src   <= grant;
         out_last  <= sel_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_write_source_arbiter.sv
module tb_write_source_arbiter;

   localparam int DW = 16;
   localparam int NS = 4;
   localparam int SW = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [NS-1:0]    src_valid;
   logic [NS*DW-1:0] src_data;
   logic [NS-1:0]    src_last;
   logic             out_ready;

   logic [NS-1:0] m0_src_ready, m1_src_ready;
   logic          m0_out_valid, m1_out_valid;
   logic [DW-1:0] m0_out_data,  m1_out_data;
   logic [SW-1:0] m0_out_src,   m1_out_src;
   logic          m0_out_last,  m1_out_last;
   logic          m0_busy,      m1_busy;

   write_source_arbiter #(.DATA_W(DW), .NUM_SRC(NS), .MODE(0)) dut_fixed (
      .clk(clk), .rst(rst), .src_valid(src_valid), .src_data(src_data),
      .src_last(src_last), .src_ready(m0_src_ready), .out_valid(m0_out_valid),
      .out_data(m0_out_data), .out_src(m0_out_src), .out_last(m0_out_last),
      .out_ready(out_ready), .busy(m0_busy));

   write_source_arbiter #(.DATA_W(DW), .NUM_SRC(NS), .MODE(1)) dut_rr (
      .clk(clk), .rst(rst), .src_valid(src_valid), .src_data(src_data),
      .src_last(src_last), .src_ready(m1_src_ready), .out_valid(m1_out_valid),
      .out_data(m1_out_data), .out_src(m1_out_src), .out_last(m1_out_last),
      .out_ready(out_ready), .busy(m1_busy));

   // ---------------- scoreboard / counters ----------------
   int checks = 0;
   int errors = 0;
   logic [DW-1:0] exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l,
                        input logic [15:0] d0, input logic [15:0] d1,
                        input logic [15:0] d2, input logic [15:0] d3,
                        input logic ordy);
      rst       = r;
      src_valid = v;
      src_last  = l;
      src_data  = {d3, d2, d1, d0};
      out_ready = ordy;
   endtask

   // Called at posedge+1; leaves the bench at posedge+1 with reset released.
   task automatic do_reset(input int n);
      drive(1'b1, 4'b0, 4'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // ---------------- vector table (fixed-priority instance) ----------------
   typedef struct {
      logic [3:0]  valid;
      logic [3:0]  last;
      logic [15:0] d0, d1, d2, d3;
      logic [3:0]  e_rdy;
      logic        e_ov;
      logic [15:0] e_data;
      logic [1:0]  e_src;
      logic        e_last;
      logic        e_busy;
   } vec_t;

   vec_t tbl[$];

   task automatic addv(input logic [3:0] v, input logic [3:0] l,
                       input logic [15:0] d0, input logic [15:0] d1,
                       input logic [15:0] d2, input logic [15:0] d3,
                       input logic [3:0] e_rdy, input logic e_ov,
                       input logic [15:0] e_data, input logic [1:0] e_src,
                       input logic e_last, input logic e_busy);
      vec_t t;
      t.valid = v; t.last = l; t.d0 = d0; t.d1 = d1; t.d2 = d2; t.d3 = d3;
      t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_data = e_data; t.e_src = e_src;
      t.e_last = e_last; t.e_busy = e_busy;
      tbl.push_back(t);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      int pops;
      logic adv;
      logic [15:0] w;

      // idle after reset: everything stays low
      for (int i = 0; i < 5; i++)
         addv(4'b0000, 4'b0000, 0, 0, 0, 0,  4'b0000, 0, 16'h0, 0, 0, 0);
      // fixed priority: sources 1 and 3 each send a 3-word burst
      addv(4'b1010, 4'b0000, 0, 16'hA1, 0, 16'hB1,  4'b0000, 0, 16'h0,  0, 0, 0);
      addv(4'b1010, 4'b0000, 0, 16'hA1, 0, 16'hB1,  4'b0010, 0, 16'h0,  0, 0, 1);
      addv(4'b1010, 4'b0000, 0, 16'hA2, 0, 16'hB1,  4'b0010, 1, 16'hA1, 1, 0, 1);
      addv(4'b1010, 4'b0010, 0, 16'hA3, 0, 16'hB1,  4'b0010, 1, 16'hA2, 1, 0, 1);
      addv(4'b1000, 4'b0000, 0, 0,      0, 16'hB1,  4'b0000, 1, 16'hA3, 1, 1, 0);
      addv(4'b1000, 4'b0000, 0, 0,      0, 16'hB1,  4'b1000, 0, 16'hA3, 1, 1, 1);
      addv(4'b1000, 4'b0000, 0, 0,      0, 16'hB2,  4'b1000, 1, 16'hB1, 3, 0, 1);
      addv(4'b1000, 4'b1000, 0, 0,      0, 16'hB3,  4'b1000, 1, 16'hB2, 3, 0, 1);
      addv(4'b0000, 4'b0000, 0, 0,      0, 0,       4'b0000, 1, 16'hB3, 3, 1, 0);
      addv(4'b0000, 4'b0000, 0, 0,      0, 0,       4'b0000, 0, 16'hB3, 3, 1, 0);
      // lock integrity: source 0 requests during source 3's burst, source 3 gaps
      addv(4'b1000, 4'b0000, 0,      0, 0, 16'hC1,  4'b0000, 0, 16'hB3, 3, 1, 0);
      addv(4'b1000, 4'b0000, 0,      0, 0, 16'hC1,  4'b1000, 0, 16'hB3, 3, 1, 1);
      addv(4'b1001, 4'b0001, 16'hD1, 0, 0, 16'hC2,  4'b1000, 1, 16'hC1, 3, 0, 1);
      addv(4'b0001, 4'b0001, 16'hD1, 0, 0, 0,       4'b1000, 1, 16'hC2, 3, 0, 1);
      addv(4'b0001, 4'b0001, 16'hD1, 0, 0, 0,       4'b1000, 0, 16'hC2, 3, 0, 1);
      addv(4'b1001, 4'b0001, 16'hD1, 0, 0, 16'hC3,  4'b1000, 0, 16'hC2, 3, 0, 1);
      addv(4'b1001, 4'b1001, 16'hD1, 0, 0, 16'hC4,  4'b1000, 1, 16'hC3, 3, 0, 1);
      addv(4'b0001, 4'b0001, 16'hD1, 0, 0, 0,       4'b0000, 1, 16'hC4, 3, 1, 0);
      addv(4'b0001, 4'b0001, 16'hD1, 0, 0, 0,       4'b0001, 0, 16'hC4, 3, 1, 1);
      addv(4'b0000, 4'b0000, 0,      0, 0, 0,       4'b0000, 1, 16'hD1, 0, 1, 0);
      addv(4'b0000, 4'b0000, 0,      0, 0, 0,       4'b0000, 0, 16'hD1, 0, 1, 0);

      do_reset(3);
      for (int k = 0; k < tbl.size(); k++) begin
         drive(1'b0, tbl[k].valid, tbl[k].last, tbl[k].d0, tbl[k].d1,
               tbl[k].d2, tbl[k].d3, 1'b1);
         @(negedge clk);
         chk($sformatf("v%0d_src_ready", k), 64'(m0_src_ready), 64'(tbl[k].e_rdy));
         chk($sformatf("v%0d_out_valid", k), 64'(m0_out_valid), 64'(tbl[k].e_ov));
         chk($sformatf("v%0d_out_data", k),  64'(m0_out_data),  64'(tbl[k].e_data));
         chk($sformatf("v%0d_out_src", k),   64'(m0_out_src),   64'(tbl[k].e_src));
         chk($sformatf("v%0d_out_last", k),  64'(m0_out_last),  64'(tbl[k].e_last));
         chk($sformatf("v%0d_busy", k),      64'(m0_busy),      64'(tbl[k].e_busy));
         next_cycle();
      end

      // round-robin: all sources request single-beat bursts continuously
      do_reset(2);
      drive(1'b0, 4'b1111, 4'b1111, 16'h10, 16'h11, 16'h12, 16'h13, 1'b1);
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk);
         chk($sformatf("rr%0d_busy", c), 64'(m1_busy), 64'(c % 2));
         chk($sformatf("rr%0d_out_valid", c), 64'(m1_out_valid), 64'((c >= 2) && (c % 2 == 0)));
         if ((c >= 2) && (c % 2 == 0)) begin
            chk($sformatf("rr%0d_out_src", c), 64'(m1_out_src), 64'((c / 2 - 1) % 4));
            chk($sformatf("rr%0d_out_data", c), 64'(m1_out_data), 64'(16'h10 + (c / 2 - 1) % 4));
         end
         next_cycle();
      end

      // backpressure: 4-word burst from source 2, output stalled 3 cycles after word 2
      do_reset(2);
      exp_q.delete();
      for (int k = 0; k < 4; k++) exp_q.push_back(16'hE1 + 16'(k));
      idx = 0;
      pops = 0;
      for (int c = 0; c < 12; c++) begin
         w = 16'hE1 + 16'(idx);
         drive(1'b0, (idx < 4) ? 4'b0100 : 4'b0000, (idx == 3) ? 4'b0100 : 4'b0000,
               0, 0, w, 0, !(c >= 3 && c <= 5));
         @(negedge clk);
         if (c >= 3 && c <= 5) begin
            chk($sformatf("bp%0d_stall_ready", c), 64'(m0_src_ready[2]), 64'(0));
            chk($sformatf("bp%0d_stall_valid", c), 64'(m0_out_valid), 64'(1));
            chk($sformatf("bp%0d_stall_data", c), 64'(m0_out_data), 64'(16'hE2));
         end
         if (m0_out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk($sformatf("bp%0d_extra_word", c), 64'(m0_out_data), 64'hFFFF_FFFF);
            end else begin
               w = exp_q.pop_front();
               chk($sformatf("bp%0d_data", c), 64'(m0_out_data), 64'(w));
               chk($sformatf("bp%0d_src", c), 64'(m0_out_src), 64'(2));
               chk($sformatf("bp%0d_last", c), 64'(m0_out_last), 64'(w == 16'hE4));
               pops++;
            end
         end
         adv = src_valid[2] && m0_src_ready[2];
         next_cycle();
         if (adv) idx++;
      end
      chk("bp_words_delivered", 64'(pops), 64'(4));

      // reset mid-burst on the round-robin instance (rr_ptr advanced first)
      do_reset(2);
      drive(1'b0, 4'b0100, 4'b0100, 0, 0, 16'h66, 0, 1'b1);
      @(negedge clk);
      chk("rst_c0_busy", 64'(m1_busy), 64'(0));
      next_cycle();
      @(negedge clk);
      chk("rst_c1_ready", 64'(m1_src_ready), 64'(4'b0100));
      next_cycle();
      drive(1'b0, 4'b0100, 4'b0000, 0, 0, 16'h67, 0, 1'b0);
      @(negedge clk);
      chk("rst_c2_out_valid", 64'(m1_out_valid), 64'(1));
      chk("rst_c2_out_data", 64'(m1_out_data), 64'(16'h66));
      next_cycle();
      @(negedge clk);
      chk("rst_c3_busy", 64'(m1_busy), 64'(1));
      chk("rst_c3_out_valid", 64'(m1_out_valid), 64'(1));
      chk("rst_c3_ready", 64'(m1_src_ready), 64'(0));
      next_cycle();
      rst = 1'b1;
      next_cycle();
      drive(1'b0, 4'b1111, 4'b1111, 16'h20, 16'h21, 16'h22, 16'h23, 1'b1);
      @(negedge clk);
      chk("rst_c5_out_valid", 64'(m1_out_valid), 64'(0));
      chk("rst_c5_busy", 64'(m1_busy), 64'(0));
      chk("rst_c5_ready", 64'(m1_src_ready), 64'(0));
      next_cycle();
      @(negedge clk);
      chk("rst_c6_rr_restart", 64'(m1_src_ready), 64'(4'b0001));
      next_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/write_source_arbiter.md
Name: write_source_arbiter

Overview:
- Parametrised successor to the one-bit write-source mux.
- Arbitrates NUM_SRC write sources (layer loader, file loader, decompressor, CNN result path, …) onto one registered DATA_W-wide write stream toward the memory/write path.
- Adds valid/ready handshakes, burst locking on a per-source last flag, and selectable fixed-priority or round-robin arbitration.
- Sits between the source engines and the single memory write port.

Parameters:
- DATA_W, 16, width of each source data word and of out_data.
- NUM_SRC, 4, number of sources (legal range 2..16).
- MODE, 0, arbitration mode: 0 = fixed priority (index 0 highest), 1 = round-robin.
- SRC_W, $clog2(NUM_SRC), width of out_src (derived; never overridden).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- src_valid  in  NUM_SRC  per-source word valid.
- src_data  in  NUM_SRC*DATA_W  packed source words; source i occupies bits [i*DATA_W +: DATA_W].
- src_last  in  NUM_SRC  per-source end-of-burst flag, qualified by valid.
- src_ready  out  NUM_SRC  per-source accept; at most one bit high at any time.
- out_valid  out  1  output word valid.
- out_data  out  DATA_W  registered output word.
- out_src  out  SRC_W  index of the source that produced out_data.
- out_last  out  1  registered last flag of that word.
- out_ready  in  1  downstream accept.
- busy  out  1  high while a burst is locked (state LOCK).

Behaviour:
- Reset (rst=1 at a clock edge) forces:
  - state=IDLE, grant=0, rr_ptr=0;
  - out_valid=0, out_data=0, out_src=0, out_last=0, busy=0.
  - src_ready is 0 while state=IDLE, so it is 0 after reset.
  - Reset mid-burst drops any held output word and the lock; no partial-burst recovery.
- State IDLE:
  - src_ready=0.
  - If any src_valid is set, pick a winner:
    - MODE 0: lowest set index.
    - MODE 1: first set index searching upward from rr_ptr, wrapping modulo NUM_SRC.
  - On the next edge, register grant=winner and go to LOCK.
  - No valid: stay in IDLE.
  - Arbitration costs exactly one cycle per burst.
- State LOCK:
  - src_ready[grant] = (!out_valid || out_ready); all other src_ready bits are 0.
  - Beat accept condition: src_valid[grant] && src_ready[grant].
  - On accept, next edge: out_data=src_data[grant], out_src=grant, out_last=src_last[grant], out_valid=1.
  - If out_valid && out_ready and no new accept: out_valid=0 next edge.
  - Accepting a beat with src_last=1 returns to IDLE next edge; in MODE 1, rr_ptr=(grant+1) mod NUM_SRC (wraps NUM_SRC-1 → 0). rr_ptr is unchanged in MODE 0.
  - Granted source dropping valid mid-burst: stay locked, insert bubbles, never re-arbitrate.
  - Valid on other sources never preempts the lock.
- Latency: src_valid rising in IDLE at cycle 0 gives grant at cycle 1, first accept at cycle 1, out_valid at cycle 2. Sustained throughput within a burst is 1 word/cycle while out_ready=1.
- Backpressure:
  - While out_valid=1 && out_ready=0, out_data, out_src and out_last hold stable, and src_ready[grant]=0.
  - Simultaneous out_ready=1 and a new accept: the output register is overwritten in the same edge, with no bubble.
- busy=1 exactly when state=LOCK.
- Single-beat burst (src_last=1 on the first word): returns to IDLE after one accept. Back-to-back single-beat bursts run at 1 word per 2 cycles.

Test Plan:
1. Reset/idle: rst held 3 cycles, then all src_valid=0 for 5 cycles → out_valid=0, src_ready=0, busy=0 throughout.
2. Fixed priority, MODE=0: src_valid=4'b1010 from the same cycle, each source sends a 3-word burst (last on word 3) → source 1 wins first; out_src=1 for words A1..A3, then one idle cycle, then out_src=3 for B1..B3; first out_valid 2 cycles after valid.
3. Round-robin, MODE=1, NUM_SRC=4: all four sources continuously request single-beat bursts → out_src sequence 0,1,2,3,0 (wrap), one word per 2 cycles.
4. Backpressure: during a 4-word burst from source 2, hold out_ready=0 for 3 cycles after word 2 → out_data stays word 2, src_ready[2]=0; after release, words 3 and 4 follow with no loss or duplication.
5. Lock integrity: source 0 (highest priority) raises valid mid-burst of source 3; source 3 also drops valid for 2 cycles → bubbles appear, out_src stays 3 until src_last, then source 0 is granted.
6. Reset mid-burst: assert rst while out_valid=1 and out_ready=0 → next cycle out_valid=0, busy=0, rr_ptr=0, and a fresh request arbitrates normally.
